// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller and execute datapath:
// FSM state encoding, legal opcode constants and PC source encoding.
package multicycle_control_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] PC_HOLD   = 3'd0;
    localparam logic [2:0] PC_PLUS4  = 3'd1;
    localparam logic [2:0] PC_BRANCH = 3'd2;
    localparam logic [2:0] PC_JAL    = 3'd3;
    localparam logic [2:0] PC_JALR   = 3'd4;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_wait.sv
// Memory wait timer: counts consecutive waiting cycles; o_terminal is high
// during the TIMEOUT_CYCLES-th consecutive waiting cycle.
module wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);
    logic [7:0] r_count;

    // Count waiting cycles; clear has priority so entry/ready restart the window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable)
            r_count <= r_count + 8'd1;
    end

    assign o_terminal = (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP
// on illegal opcode or memory timeout, plus a retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic        i_branch_taken,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_ir_we,
    output logic        o_rf_we,
    output logic        o_pc_we,
    output logic [2:0]  o_pc_op,
    output logic [2:0]  o_state,
    output logic        o_halted,
    output logic [31:0] o_retired
);
    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [31:0] r_retired;
    logic        w_imem_req, w_dmem_req, w_dmem_we;
    logic        w_ir_we, w_rf_we, w_pc_we, w_retire;
    logic [2:0]  w_pc_sel;
    logic        w_ready, w_wait_state, w_timeout, w_clear;
    logic        w_is_mem, w_is_store;

    assign w_is_store   = (i_opcode == OP_STORE);
    assign w_is_mem     = (i_opcode == OP_LOAD) || w_is_store;
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_ready      = ((r_state == S_FETCH) && i_imem_ready) ||
                          ((r_state == S_MEM)   && i_dmem_ready);
    assign w_clear      = (w_next != r_state) || w_ready;

    wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_reset),
        .i_clear    (w_clear),
        .i_enable   (w_wait_state),
        .o_terminal (w_timeout)
    );

    // Next-state and per-state strobe decode; ready wins over timeout.
    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_ir_we    = 1'b0;
        w_rf_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = PC_HOLD;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (i_imem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: w_next = is_legal_opcode(i_opcode) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_is_mem) begin
                    w_next = S_MEM;
                end else if (i_opcode == OP_BRANCH) begin
                    w_pc_we  = 1'b1;
                    w_pc_sel = i_branch_taken ? PC_BRANCH : PC_PLUS4;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                if (i_dmem_ready) begin
                    if (w_is_store) begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = PC_PLUS4;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                w_rf_we  = (i_rd != 5'd0);
                w_pc_we  = 1'b1;
                w_pc_sel = (i_opcode == OP_JAL)  ? PC_JAL  :
                           (i_opcode == OP_JALR) ? PC_JALR : PC_PLUS4;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    // State register; reset parks in FETCH.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + 32'd1;
    end

    // Outputs are gated by reset so FETCH's request stays low while held in reset.
    assign o_imem_req = i_reset & w_imem_req;
    assign o_dmem_req = i_reset & w_dmem_req;
    assign o_dmem_we  = i_reset & w_dmem_we;
    assign o_ir_we    = i_reset & w_ir_we;
    assign o_rf_we    = i_reset & w_rf_we;
    assign o_pc_we    = i_reset & w_pc_we;
    assign o_pc_op    = (i_reset & w_pc_we) ? w_pc_sel : PC_HOLD;
    assign o_state    = r_state;
    assign o_halted   = i_reset & (r_state == S_TRAP);
    assign o_retired  = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle outputs.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        i_reset, i_branch_taken, i_imem_ready, i_dmem_ready;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic        o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_rf_we, o_pc_we, o_halted;
    logic [2:0]  o_pc_op, o_state;
    logic [31:0] o_retired;
    logic [12:0] w_obs;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_retired;
    bit          g_dready_in_fetch;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_rd(i_rd),
        .i_branch_taken(i_branch_taken), .i_imem_ready(i_imem_ready),
        .i_dmem_ready(i_dmem_ready), .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_ir_we(o_ir_we), .o_rf_we(o_rf_we), .o_pc_we(o_pc_we),
        .o_pc_op(o_pc_op), .o_state(o_state), .o_halted(o_halted), .o_retired(o_retired)
    );

    assign w_obs = {o_state, o_halted, o_imem_req, o_dmem_req, o_dmem_we,
                    o_ir_we, o_rf_we, o_pc_we, o_pc_op};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    task automatic noise();
        i_imem_ready   = 1'($urandom);
        i_dmem_ready   = 1'($urandom);
        i_branch_taken = 1'($urandom);
    endtask

    // One cycle: compare at the falling edge, advance past the rising edge.
    task automatic tick(input string tag, input logic [2:0] st, input bit halted,
                        input bit ireq, input bit dreq, input bit dwe, input bit irwe,
                        input bit rfwe, input bit pcwe, input logic [2:0] pcop, input bit retire);
        @(negedge clk);
        check_eq(tag, 32'(w_obs), 32'({st, halted, ireq, dreq, dwe, irwe, rfwe, pcwe, pcop}));
        check_eq({tag, "_retired"}, o_retired, m_retired);
        @(posedge clk);
        #1;
        if (retire) m_retired = m_retired + 32'd1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [4:0] rd, input bit bt,
                             input int unsigned iw, input int unsigned dw, input bit abort,
                             output bit trapped);
        bit st, hit;
        logic [2:0] pcop;
        trapped = 1'b0;
        for (int unsigned k = 0; k < TO; k++) begin
            i_opcode       = 7'($urandom);
            i_imem_ready   = (k == iw);
            i_dmem_ready   = g_dready_in_fetch ? 1'b1 : 1'($urandom);
            i_branch_taken = 1'($urandom);
            tick("fetch", S_FETCH, 0, 1, 0, 0, (k == iw), 0, 0, 3'd0, 0);
            if (k == iw) break;
        end
        if (iw >= TO) begin trapped = 1'b1; return; end
        i_opcode = op;
        i_rd     = rd;
        noise();
        tick("decode", S_DECODE, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        if (!legal(op)) begin trapped = 1'b1; return; end
        noise();
        i_branch_taken = bt;
        if (op == 7'b1100011) begin
            tick("exec_branch", S_EXEC, 0, 0, 0, 0, 0, 0, 1, bt ? 3'd2 : 3'd1, 1);
            return;
        end
        tick("exec", S_EXEC, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            st = (op == 7'b0100011);
            for (int unsigned k = 0; k < TO; k++) begin
                noise();
                i_dmem_ready = (k == dw);
                if (abort && k == 0) begin
                    i_dmem_ready = 1'b0;
                    #2;
                    i_reset = 1'b0;
                    #1;
                    check_eq("rst_mid_mem_out", 32'(w_obs), 32'({S_FETCH, 10'd0}));
                    check_eq("rst_mid_mem_retired", o_retired, 32'd0);
                    m_retired = '0;
                    @(posedge clk);
                    #1;
                    i_reset = 1'b1;
                    return;
                end
                hit = (k == dw) && st;
                tick("mem", S_MEM, 0, 0, 1, st, 0, 0, hit, hit ? 3'd1 : 3'd0, hit);
                if (k == dw) break;
            end
            if (dw >= TO) begin trapped = 1'b1; return; end
            if (st) return;
        end
        noise();
        pcop = (op == 7'b1101111) ? 3'd3 : (op == 7'b1100111) ? 3'd4 : 3'd1;
        tick("wb", S_WB, 0, 0, 0, 0, 0, (rd != 5'd0), 1, pcop, 1);
    endtask

    task automatic trap_phase(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            noise();
            i_opcode = 7'($urandom);
            tick("trap", S_TRAP, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
        end
    endtask

    task automatic do_reset();
        i_reset      = 1'b0;
        i_imem_ready = 1'b1;
        i_dmem_ready = 1'b1;
        #1;
        check_eq("reset_async_out", 32'(w_obs), 32'({S_FETCH, 10'd0}));
        check_eq("reset_async_retired", o_retired, 32'd0);
        m_retired = '0;
        @(negedge clk);
        check_eq("reset_held_out", 32'(w_obs), 32'({S_FETCH, 10'd0}));
        @(posedge clk);
        #1;
        i_reset = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        bit tr;
        int unsigned iw, dw;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        i_reset = 1'b0; i_opcode = '0; i_rd = '0; i_branch_taken = 1'b0;
        i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
        m_retired = '0; g_dready_in_fetch = 1'b0;
        @(negedge clk);
        check_eq("reset_out", 32'(w_obs), 32'({S_FETCH, 10'd0}));
        check_eq("reset_retired", o_retired, 32'd0);
        @(posedge clk); #1;
        i_reset = 1'b1;

        run_instr(7'b0110011, 5'd5, 0, 0, 0, 0, tr);
        check_eq("rtype_retired_one", o_retired, 32'd1);
        run_instr(7'b0000011, 5'd3, 0, 0, 3, 0, tr);
        run_instr(7'b1100011, 5'd7, 1, 0, 0, 0, tr);
        run_instr(7'b1101111, 5'd0, 0, 1, 0, 0, tr);
        run_instr(7'b0100011, 5'd0, 0, 2, 1, 0, tr);
        run_instr(7'b0100011, 5'd9, 0, 0, 0, 1, tr);
        g_dready_in_fetch = 1'b1;
        run_instr(7'b0010011, 5'd1, 0, 2, 0, 0, tr);
        g_dready_in_fetch = 1'b0;

        run_instr(7'b1111111, 5'd4, 0, 0, 0, 0, tr);
        check_eq("illegal_traps", 32'(tr), 32'd1);
        trap_phase(20);
        do_reset();
        run_instr(7'b0110011, 5'd2, 0, TO, 0, 0, tr);
        check_eq("imem_timeout_traps", 32'(tr), 32'd1);
        trap_phase(3);
        do_reset();
        run_instr(7'b0110011, 5'd2, 0, TO - 1, 0, 0, tr);
        check_eq("imem_ready_at_limit", 32'(tr), 32'd0);
        run_instr(7'b0000011, 5'd6, 0, 0, TO, 0, tr);
        check_eq("dmem_timeout_traps", 32'(tr), 32'd1);
        trap_phase(2);
        do_reset();

        repeat (300) begin
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 19) == 0)
                do op = 7'($urandom); while (legal(op));
            iw = ($urandom_range(0, 15) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            dw = ($urandom_range(0, 15) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            run_instr(op, 5'($urandom), 1'($urandom), iw, dw, 0, tr);
            if (tr) begin
                trap_phase($urandom_range(1, 5));
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
